// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;

  localparam int unsigned WAIT_W = 4;

  // Expands up to four byte strobes into a 32-bit lane mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with byte-lane writes, read-only overlay and read mux.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          NUM_REGS  = 8,
  parameter int unsigned          IDX_W     = 30,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic                         wr_en_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W/8-1:0]          strb_i,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic                         in_range_o,
  output logic                         is_ro_o,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] sel_d;
  logic [31:0]         mask_full;
  logic [DATA_W-1:0]   mask;

  assign mask_full = strb_to_mask(4'(strb_i));
  assign mask      = mask_full[DATA_W-1:0];

  assign in_range_o = ({1'b0, idx_i} < (IDX_W+1)'(NUM_REGS));

  always_comb begin
    sel_d     = '0;
    is_ro_o   = 1'b0;
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_i == IDX_W'(i)) begin
        sel_d[i]  = 1'b1;
        is_ro_o   = RO_MASK[i];
        rd_data_o = RO_MASK[i] ? ro_i[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  // RO entries never take a write, so they hold RESET_VAL on reg_o.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && sel_d[i] && !RO_MASK[i]) begin
          regs_q[i] <= (regs_q[i] & ~mask) | (wdata_i & mask);
        end
      end
      wr_pulse_q <= wr_en_i ? sel_d : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
    assign reg_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer: transfer FSM and wait counter in front of apb_reg_bank.
//   state  | meaning
//   IDLE   | no transfer; waiting for psel with penable low
//   SETUP  | request latched; waiting for penable
//   ACCESS | counting wait states, then one pready cycle
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         psel,
  input  logic                         penable,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned OFF_W = $clog2(DATA_W/8);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;

  apb_state_e            state_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_W-1:0]     prdata_q;

  logic                  complete_d;
  logic                  err_d;
  logic                  wr_en_d;
  logic [DATA_W-1:0]     prdata_d;
  logic [DATA_W-1:0]     rd_data;
  logic                  in_range;
  logic                  is_ro;

  if (OFF_W > 0) begin : g_unused_off
    logic unused_addr_bits;
    assign unused_addr_bits = ^paddr[OFF_W-1:0];
  end

  // The edge that raises pready also commits the write and captures read data.
  assign complete_d = psel && penable && !pready_q &&
                      (((state_q == SETUP)  && (wait_cnt_q == '0)) ||
                       ((state_q == ACCESS) && (wait_cnt_q == WAIT_W'(1))));
  assign err_d      = !in_range || (write_q && is_ro);
  assign wr_en_d    = complete_d && write_q && !err_d;
  assign prdata_d   = (!write_q && in_range) ? rd_data : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= APB_RESP_OKAY;
      prdata_q   <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= APB_RESP_OKAY;
      prdata_q  <= '0;
      if (complete_d) begin
        pready_q  <= 1'b1;
        pslverr_q <= err_d ? APB_RESP_SLVERR : APB_RESP_OKAY;
        prdata_q  <= prdata_d;
      end
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            idx_q      <= paddr[ADDR_W-1:OFF_W];
            write_q    <= pwrite;
            wdata_q    <= pwdata;
            strb_q     <= pstrb;
            wait_cnt_q <= WAIT_W'(WAIT_STATES);
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (!psel)        state_q <= IDLE;
          else if (penable) state_q <= ACCESS;
        end
        ACCESS: begin
          if (pready_q) begin
            if (psel && !penable) begin
              idx_q      <= paddr[ADDR_W-1:OFF_W];
              write_q    <= pwrite;
              wdata_q    <= pwdata;
              strb_q     <= pstrb;
              wait_cnt_q <= WAIT_W'(WAIT_STATES);
              state_q    <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end else if (!psel) begin
            state_q <= IDLE;
          end else if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_reg_bank #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .pclk       (pclk),
    .presetn    (presetn),
    .idx_i      (idx_q),
    .wr_en_i    (wr_en_d),
    .wdata_i    (wdata_q),
    .strb_i     (strb_q),
    .ro_i       (ro_i),
    .rd_data_o  (rd_data),
    .in_range_o (in_range),
    .is_ro_o    (is_ro),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: dut 0 has no wait states and RO reg 2, dut 1 has three wait states.
module tb_apb_reg_completer;

  localparam int NR = 8;
  localparam logic [31:0] RST_B = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n   [2];
  logic             psel    [2];
  logic             penable [2];
  logic             pwrite  [2];
  logic [31:0]      paddr   [2];
  logic [31:0]      pwdata  [2];
  logic [3:0]       pstrb   [2];
  logic [31:0]      prdata  [2];
  logic             pready  [2];
  logic             pslverr [2];
  logic [NR*32-1:0] reg_o   [2];
  logic [NR*32-1:0] ro_i    [2];
  logic [NR-1:0]    wr_pulse[2];

  apb_reg_completer #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(0),
    .RO_MASK(8'b0000_0100), .RESET_VAL(32'h0)
  ) dut0 (
    .pclk(clk), .presetn(rst_n[0]), .psel(psel[0]), .penable(penable[0]),
    .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .reg_o(reg_o[0]), .ro_i(ro_i[0]), .wr_pulse_o(wr_pulse[0])
  );

  apb_reg_completer #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(3),
    .RO_MASK(8'b0000_0000), .RESET_VAL(RST_B)
  ) dut1 (
    .pclk(clk), .presetn(rst_n[1]), .psel(psel[1]), .penable(penable[1]),
    .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .reg_o(reg_o[1]), .ro_i(ro_i[1]), .wr_pulse_o(wr_pulse[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    logic [7:0]  pulse;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qpop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  // acc counts negedges with psel&penable and pready low; with inputs driven just
  // after posedge this equals the ACCESS cycle number in which pready rises.
  task automatic mon(input int d);
    int   acc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n[d]) begin
        acc = 0;
        continue;
      end
      if (pready[d]) begin
        if (qsize(d) == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pready dut%0d: got pready=1 expected no response (t=%0t)", d, $time);
        end else begin
          qpop(d, e);
          check($sformatf("prdata_dut%0d", d),   64'(prdata[d]),   64'(e.rdata));
          check($sformatf("pslverr_dut%0d", d),  64'(pslverr[d]),  64'(e.err));
          check($sformatf("latency_dut%0d", d),  64'(acc),         64'(e.acc));
          check($sformatf("wr_pulse_dut%0d", d), 64'(wr_pulse[d]), 64'(e.pulse));
        end
        acc = 0;
      end else begin
        check($sformatf("quiet_outputs_dut%0d", d),
              {23'd0, pslverr[d], wr_pulse[d], prdata[d]}, 64'd0);
        if (psel[d] && penable[d]) acc++;
        else if (!psel[d])         acc = 0;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic setup_phase(input int d, input bit wr, input logic [31:0] a,
                             input logic [31:0] dat, input logic [3:0] s);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = dat; pstrb[d] = s;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // Call just after a posedge; returns just after the posedge that shows pready.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_err,
                      input logic [7:0] exp_pulse, input bit hold);
    exp_t e;
    bit   done = 1'b0;
    e.rdata = exp_rd; e.err = exp_err; e.pulse = exp_pulse;
    e.acc   = (d == 0) ? 1 : 4;
    qpush(d, e);
    setup_phase(d, wr, a, dat, s);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < 32 && !done; i++) begin
      @(posedge clk); #1;
      done = pready[d];
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout_dut%0d addr=%h: got no pready expected pready within 32 cycles", d, a);
    end
    if (!hold) bus_idle(d);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; ro_i[d] = '0;
    end
    ro_i[0][2*32 +: 32] = 32'hC0FF_EE02;
    ro_i[0][5*32 +: 32] = 32'h5555_0005;
    tick(2);
    check("rst_pready_dut0",  64'(pready[0]),  64'd0);
    check("rst_prdata_dut0",  64'(prdata[0]),  64'd0);
    check("rst_pslverr_dut0", 64'(pslverr[0]), 64'd0);
    check("rst_pulse_dut0",   64'(wr_pulse[0]), 64'd0);
    check("rst_reg1_dut0",    64'(reg_o[0][1*32 +: 32]), 64'd0);
    check("rst_pready_dut1",  64'(pready[1]),  64'd0);
    check("rst_reg0_dut1",    64'(reg_o[1][0 +: 32]), 64'(RST_B));
    check("rst_reg7_dut1",    64'(reg_o[1][7*32 +: 32]), 64'(RST_B));
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick(1);

    // dut0: basic write/read, errors, zero strobe, back-to-back, stray penable
    xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 8'h02, 0);
    check("reg1_after_write", 64'(reg_o[0][1*32 +: 32]), 64'hDEAD_BEEF);
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 8'h00, 0);
    xfer(0, 1, 32'h100, 32'h1111_1111, 4'hF, 32'h0, 1, 8'h00, 0);
    xfer(0, 1, 32'h8, 32'h2222_2222, 4'hF, 32'h0, 1, 8'h00, 0);
    check("ro_reg2_unchanged", 64'(reg_o[0][2*32 +: 32]), 64'd0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 32'hC0FF_EE02, 0, 8'h00, 0);
    xfer(0, 0, 32'h100, 32'h0, 4'h0, 32'h0, 1, 8'h00, 0);
    xfer(0, 1, 32'hC, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 8'h08, 0);
    xfer(0, 0, 32'hC, 32'h0, 4'h0, 32'h0, 0, 8'h00, 0);
    tick(1);
    xfer(0, 1, 32'h10, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 8'h10, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 8'h00, 1);
    xfer(0, 1, 32'h14, 32'h55AA_55AA, 4'hF, 32'h0, 0, 8'h20, 1);
    xfer(0, 0, 32'h14, 32'h0, 4'h0, 32'h55AA_55AA, 0, 8'h00, 0);
    tick(1);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    tick(3);
    bus_idle(0);
    tick(1);
    xfer(0, 0, 32'h7, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 8'h00, 0);

    // dut1: wait states, byte strobes, abort, reset mid-transfer
    xfer(1, 0, 32'h0, 32'h0, 4'h0, RST_B, 0, 8'h00, 0);
    xfer(1, 1, 32'h8, 32'h1122_3344, 4'hF, 32'h0, 0, 8'h04, 0);
    xfer(1, 1, 32'h8, 32'hAABB_CCDD, 4'b0101, 32'h0, 0, 8'h04, 0);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, 32'h11BB_33DD, 0, 8'h00, 0);
    check("strb_merge_reg2", 64'(reg_o[1][2*32 +: 32]), 64'h11BB_33DD);

    setup_phase(1, 1, 32'h4, 32'hFFFF_0000, 4'hF);
    tick(1); penable[1] = 1'b1;
    tick(2); bus_idle(1);
    tick(6);
    check("abort_reg1_unchanged", 64'(reg_o[1][1*32 +: 32]), 64'(RST_B));

    setup_phase(1, 1, 32'h4, 32'hCAFE_F00D, 4'hF);
    tick(1); penable[1] = 1'b1;
    tick(2);
    rst_n[1] = 1'b0;
    #1;
    check("midrst_pready",  64'(pready[1]),  64'd0);
    check("midrst_prdata",  64'(prdata[1]),  64'd0);
    check("midrst_pulse",   64'(wr_pulse[1]), 64'd0);
    check("midrst_reg2",    64'(reg_o[1][2*32 +: 32]), 64'(RST_B));
    bus_idle(1);
    tick(2);
    rst_n[1] = 1'b1;
    tick(4);
    check("midrst_reg1", 64'(reg_o[1][1*32 +: 32]), 64'(RST_B));
    xfer(1, 0, 32'h4, 32'h0, 4'h0, RST_B, 0, 8'h00, 0);

    tick(3);
    check("sb_drained_dut0", 64'(q0.size()), 64'd0);
    check("sb_drained_dut1", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
